// File: rtl/reg_seq_controller_pkg.sv
// Shared encodings for the register-sequence controller: sequence codes,
// address-select codes and the fixed register numbers used by A/B selects.
package reg_seq_controller_pkg;

   localparam logic [2:0] SEQ_NONE    = 3'd0;
   localparam logic [2:0] SEQ_LDA_RDB = 3'd1;
   localparam logic [2:0] SEQ_LDA_IMM = 3'd2;

   localparam logic [1:0] A_SEL_ARGA  = 2'd0;
   localparam logic [1:0] A_SEL_RA    = 2'd1;

   localparam logic [2:0] B_SEL_ARGB  = 3'd0;
   localparam logic [2:0] B_SEL_RB    = 3'd1;

   localparam logic [3:0] REG_RA      = 4'd1;
   localparam logic [3:0] REG_RB      = 4'd2;

   // Both load sequences read and write back register A.
   function automatic logic seq_uses_a(input logic [2:0] seq);
      return (seq == SEQ_LDA_RDB) || (seq == SEQ_LDA_IMM);
   endfunction

endpackage

// File: rtl/reg_seq_controller.sv
// Four-phase instruction sequencer: latches decoded register addresses and
// drives register-file read/write and condition-code enables per phase.
module reg_seq_controller
   import reg_seq_controller_pkg::*;
(
   input  logic        CLK,
   input  logic        RESET,
   input  logic        FETCH,
   input  logic        DECODE,
   input  logic        EXECUTE,
   input  logic        COMMIT,
   input  logic [2:0]  REG_SEQX,
   input  logic [1:0]  REGA_ADDRX,
   input  logic [2:0]  REGB_ADDRX,
   input  logic [3:0]  ARGA_X,
   input  logic [3:0]  ARGB_X,
   input  logic        CCL_LD_X,
   output logic [3:0]  REGA_ADDR,
   output logic [3:0]  REGB_ADDR,
   output logic        IMM_SEL,
   output logic        REGA_RD,
   output logic        REGB_RD,
   output logic        REGA_WEN,
   output logic        CCL_EN,
   output logic        PHASE_ERR,
   output logic        SEQ_ERR,
   output logic [15:0] COMMIT_CNT,
   output logic [1:0]  STATE_DBG
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_FETCHED  = 2'd1,
      S_DECODED  = 2'd2,
      S_EXECUTED = 2'd3
   } state_t;

   state_t      state;
   logic [2:0]  seq_q;
   logic        ccl_ld_q;
   logic [15:0] commit_cnt_q;

   logic [2:0]  strobe_cnt;
   logic        one_strobe;
   logic        multi_strobe;
   logic        legal_decode;
   logic        legal_exec;
   logic        legal_commit;
   logic        decode_reserved;
   logic [3:0]  rega_addr_d;
   logic [3:0]  regb_addr_d;

   assign strobe_cnt   = {2'b00, FETCH} + {2'b00, DECODE} + {2'b00, EXECUTE} + {2'b00, COMMIT};
   assign one_strobe   = (strobe_cnt == 3'd1);
   assign multi_strobe = (strobe_cnt > 3'd1);

   assign legal_decode = one_strobe && DECODE  && (state == S_FETCHED);
   assign legal_exec   = one_strobe && EXECUTE && (state == S_DECODED);
   assign legal_commit = one_strobe && COMMIT  && (state == S_EXECUTED);

   assign decode_reserved = (REG_SEQX > SEQ_LDA_IMM) || (REGA_ADDRX > A_SEL_RA) ||
                            (REGB_ADDRX > B_SEL_RB);

   always_comb begin
      rega_addr_d = 4'd0;
      regb_addr_d = 4'd0;
      if (!decode_reserved) begin
         rega_addr_d = (REGA_ADDRX == A_SEL_ARGA) ? ARGA_X : REG_RA;
         regb_addr_d = (REGB_ADDRX == B_SEL_ARGB) ? ARGB_X : REG_RB;
      end
   end

   // Single-strobe phase progression; any out-of-order or overlapping strobe
   // drops back to IDLE and flags PHASE_ERR for one cycle.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state        <= S_IDLE;
         seq_q        <= SEQ_NONE;
         ccl_ld_q     <= 1'b0;
         commit_cnt_q <= 16'd0;
         REGA_ADDR    <= 4'd0;
         REGB_ADDR    <= 4'd0;
         IMM_SEL      <= 1'b0;
         PHASE_ERR    <= 1'b0;
         SEQ_ERR      <= 1'b0;
      end else begin
         PHASE_ERR <= 1'b0;
         SEQ_ERR   <= 1'b0;
         if (multi_strobe) begin
            state     <= S_IDLE;
            PHASE_ERR <= 1'b1;
         end else if (FETCH) begin
            state <= S_FETCHED;
         end else if (DECODE) begin
            if (legal_decode) begin
               state     <= S_DECODED;
               REGA_ADDR <= rega_addr_d;
               REGB_ADDR <= regb_addr_d;
               ccl_ld_q  <= CCL_LD_X;
               if (decode_reserved) begin
                  seq_q   <= SEQ_NONE;
                  IMM_SEL <= 1'b0;
                  SEQ_ERR <= 1'b1;
               end else begin
                  seq_q   <= REG_SEQX;
                  IMM_SEL <= (REG_SEQX == SEQ_LDA_IMM);
               end
            end else begin
               state     <= S_IDLE;
               PHASE_ERR <= 1'b1;
            end
         end else if (EXECUTE) begin
            if (legal_exec) begin
               state <= S_EXECUTED;
            end else begin
               state     <= S_IDLE;
               PHASE_ERR <= 1'b1;
            end
         end else if (COMMIT) begin
            state <= S_IDLE;
            if (legal_commit) begin
               commit_cnt_q <= commit_cnt_q + 16'd1;
            end else begin
               PHASE_ERR <= 1'b1;
            end
         end
      end
   end

   // Register-file strobes are combinational so they land in the phase cycle itself.
   assign REGA_RD    = legal_exec && seq_uses_a(seq_q);
   assign REGB_RD    = legal_exec && (seq_q == SEQ_LDA_RDB);
   assign REGA_WEN   = legal_commit && seq_uses_a(seq_q);
   assign CCL_EN     = legal_commit && ccl_ld_q;
   assign COMMIT_CNT = commit_cnt_q;
   assign STATE_DBG  = state;

endmodule

// File: tb/tb_reg_seq_controller.sv
// Directed bench for reg_seq_controller: a phase-level reference model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_reg_seq_controller;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        FETCH = 1'b0, DECODE = 1'b0, EXECUTE = 1'b0, COMMIT = 1'b0;
   logic [2:0]  REG_SEQX = 3'd0;
   logic [1:0]  REGA_ADDRX = 2'd0;
   logic [2:0]  REGB_ADDRX = 3'd0;
   logic [3:0]  ARGA_X = 4'd0, ARGB_X = 4'd0;
   logic        CCL_LD_X = 1'b0;
   logic [3:0]  REGA_ADDR, REGB_ADDR;
   logic        IMM_SEL, REGA_RD, REGB_RD, REGA_WEN, CCL_EN, PHASE_ERR, SEQ_ERR;
   logic [15:0] COMMIT_CNT;
   logic [1:0]  STATE_DBG;

   int tests = 0;
   int fails = 0;

   // ---------------- clock / reset ----------------
   always #5 CLK = ~CLK;

   reg_seq_controller dut (
      .CLK(CLK), .RESET(RESET), .FETCH(FETCH), .DECODE(DECODE), .EXECUTE(EXECUTE),
      .COMMIT(COMMIT), .REG_SEQX(REG_SEQX), .REGA_ADDRX(REGA_ADDRX), .REGB_ADDRX(REGB_ADDRX),
      .ARGA_X(ARGA_X), .ARGB_X(ARGB_X), .CCL_LD_X(CCL_LD_X), .REGA_ADDR(REGA_ADDR),
      .REGB_ADDR(REGB_ADDR), .IMM_SEL(IMM_SEL), .REGA_RD(REGA_RD), .REGB_RD(REGB_RD),
      .REGA_WEN(REGA_WEN), .CCL_EN(CCL_EN), .PHASE_ERR(PHASE_ERR), .SEQ_ERR(SEQ_ERR),
      .COMMIT_CNT(COMMIT_CNT), .STATE_DBG(STATE_DBG)
   );

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // m_ph counts completed phases of the current instruction (0 = none).
   int m_ph = 0, m_a = 0, m_b = 0, m_imm = 0, m_seq = 0, m_ccl = 0;
   int m_perr = 0, m_serr = 0, m_cnt = 0;

   always @(posedge CLK or posedge RESET) begin
      int n;
      if (RESET) begin
         m_ph = 0; m_a = 0; m_b = 0; m_imm = 0; m_seq = 0; m_ccl = 0;
         m_perr = 0; m_serr = 0; m_cnt = 0;
      end else begin
         n = int'(FETCH) + int'(DECODE) + int'(EXECUTE) + int'(COMMIT);
         m_perr = 0;
         m_serr = 0;
         if (n > 1) begin
            m_ph = 0; m_perr = 1;
         end else if (FETCH) begin
            m_ph = 1;
         end else if (DECODE) begin
            if (m_ph == 1) begin
               m_ph  = 2;
               m_ccl = int'(CCL_LD_X);
               if (REG_SEQX > 2 || REGA_ADDRX > 1 || REGB_ADDRX > 1) begin
                  m_seq = 0; m_a = 0; m_b = 0; m_imm = 0; m_serr = 1;
               end else begin
                  m_seq = int'(REG_SEQX);
                  m_a   = (REGA_ADDRX == 0) ? int'(ARGA_X) : 1;
                  m_b   = (REGB_ADDRX == 0) ? int'(ARGB_X) : 2;
                  m_imm = (REG_SEQX == 2) ? 1 : 0;
               end
            end else begin
               m_ph = 0; m_perr = 1;
            end
         end else if (EXECUTE) begin
            if (m_ph == 2) m_ph = 3;
            else begin m_ph = 0; m_perr = 1; end
         end else if (COMMIT) begin
            if (m_ph == 3) m_cnt = (m_cnt + 1) % 65536;
            else m_perr = 1;
            m_ph = 0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always begin
      int n, e_ok, c_ok;
      @(negedge CLK);
      #2;
      n    = int'(FETCH) + int'(DECODE) + int'(EXECUTE) + int'(COMMIT);
      e_ok = (n == 1 && EXECUTE && m_ph == 2) ? 1 : 0;
      c_ok = (n == 1 && COMMIT && m_ph == 3) ? 1 : 0;
      check("cyc rega_addr", int'(REGA_ADDR), m_a);
      check("cyc regb_addr", int'(REGB_ADDR), m_b);
      check("cyc imm_sel",   int'(IMM_SEL), m_imm);
      check("cyc phase_err", int'(PHASE_ERR), m_perr);
      check("cyc seq_err",   int'(SEQ_ERR), m_serr);
      check("cyc commit_cnt", int'(COMMIT_CNT), m_cnt);
      check("cyc state",     int'(STATE_DBG), m_ph);
      check("cyc rega_rd",   int'(REGA_RD), (e_ok && m_seq != 0) ? 1 : 0);
      check("cyc regb_rd",   int'(REGB_RD), (e_ok && m_seq == 1) ? 1 : 0);
      check("cyc rega_wen",  int'(REGA_WEN), (c_ok && m_seq != 0) ? 1 : 0);
      check("cyc ccl_en",    int'(CCL_EN), (c_ok && m_ccl == 1) ? 1 : 0);
   end

   // ---------------- driver tasks ----------------
   task automatic strobe(input logic f, input logic d, input logic e, input logic c);
      @(negedge CLK);
      RESET = 1'b0;
      FETCH = f; DECODE = d; EXECUTE = e; COMMIT = c;
      #2;
   endtask

   task automatic fields(input logic [2:0] seq, input logic [1:0] ax, input logic [2:0] bx,
                         input logic [3:0] a, input logic [3:0] b, input logic ccl);
      REG_SEQX = seq; REGA_ADDRX = ax; REGB_ADDRX = bx;
      ARGA_X = a; ARGB_X = b; CCL_LD_X = ccl;
   endtask

   task automatic idle();
      strobe(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      repeat (2) @(negedge CLK);
      #2;
      check("reset rega_addr", int'(REGA_ADDR), 0);
      check("reset commit_cnt", int'(COMMIT_CNT), 0);
      check("reset state", int'(STATE_DBG), 0);
      idle();

      // LDA_RDB through all four phases
      fields(3'd1, 2'd0, 3'd0, 4'd3, 4'd5, 1'b1);
      strobe(1, 0, 0, 0);
      strobe(0, 1, 0, 0);
      strobe(0, 0, 1, 0);
      check("rdb rega_addr", int'(REGA_ADDR), 3);
      check("rdb regb_addr", int'(REGB_ADDR), 5);
      check("rdb rega_rd", int'(REGA_RD), 1);
      check("rdb regb_rd", int'(REGB_RD), 1);
      strobe(0, 0, 0, 1);
      check("rdb rega_wen", int'(REGA_WEN), 1);
      check("rdb ccl_en", int'(CCL_EN), 1);
      idle();
      check("rdb commit_cnt", int'(COMMIT_CNT), 1);

      // LDA_IMM using RA, no condition-code load
      fields(3'd2, 2'd1, 3'd0, 4'd7, 4'd9, 1'b0);
      strobe(1, 0, 0, 0);
      strobe(0, 1, 0, 0);
      strobe(0, 0, 1, 0);
      check("imm rega_addr", int'(REGA_ADDR), 1);
      check("imm imm_sel", int'(IMM_SEL), 1);
      check("imm rega_rd", int'(REGA_RD), 1);
      check("imm regb_rd", int'(REGB_RD), 0);
      strobe(0, 0, 0, 1);
      check("imm rega_wen", int'(REGA_WEN), 1);
      check("imm ccl_en", int'(CCL_EN), 0);
      idle();
      check("imm commit_cnt", int'(COMMIT_CNT), 2);

      // phase errors: EXECUTE from IDLE, then DECODE+EXECUTE together
      strobe(0, 0, 1, 0);
      idle();
      check("perr exec_idle", int'(PHASE_ERR), 1);
      strobe(0, 1, 1, 0);
      check("perr between", int'(PHASE_ERR), 0);
      idle();
      check("perr multi", int'(PHASE_ERR), 1);
      check("perr state", int'(STATE_DBG), 0);
      idle();
      check("perr cleared", int'(PHASE_ERR), 0);

      // reserved sequence code
      fields(3'd5, 2'd0, 3'd0, 4'd4, 4'd6, 1'b0);
      strobe(1, 0, 0, 0);
      strobe(0, 1, 0, 0);
      strobe(0, 0, 1, 0);
      check("serr pulse", int'(SEQ_ERR), 1);
      check("serr rega_rd", int'(REGA_RD), 0);
      check("serr rega_addr", int'(REGA_ADDR), 0);
      strobe(0, 0, 0, 1);
      check("serr rega_wen", int'(REGA_WEN), 0);
      idle();
      check("serr commit_cnt", int'(COMMIT_CNT), 3);

      // FETCH after DECODE aborts silently; RA/RB selects
      fields(3'd1, 2'd1, 3'd1, 4'd0, 4'd0, 1'b1);
      strobe(1, 0, 0, 0);
      strobe(0, 1, 0, 0);
      strobe(1, 0, 0, 0);
      check("abort regb_addr", int'(REGB_ADDR), 2);
      idle();
      check("abort no perr", int'(PHASE_ERR), 0);
      fields(3'd2, 2'd0, 3'd0, 4'd4, 4'd6, 1'b0);
      strobe(0, 1, 0, 0);
      strobe(0, 0, 1, 0);
      strobe(0, 0, 0, 1);
      idle();
      check("hold rega_addr", int'(REGA_ADDR), 4);
      check("hold imm_sel", int'(IMM_SEL), 1);
      check("abort commit_cnt", int'(COMMIT_CNT), 4);

      // reset between EXECUTE and COMMIT
      fields(3'd1, 2'd0, 3'd0, 4'd3, 4'd5, 1'b1);
      strobe(1, 0, 0, 0);
      strobe(0, 1, 0, 0);
      strobe(0, 0, 1, 0);
      @(negedge CLK);
      FETCH = 0; DECODE = 0; EXECUTE = 0; COMMIT = 0;
      RESET = 1'b1;
      #1;
      check("rst rega_addr", int'(REGA_ADDR), 0);
      check("rst regb_addr", int'(REGB_ADDR), 0);
      check("rst commit_cnt", int'(COMMIT_CNT), 0);
      strobe(0, 0, 0, 1);
      check("rst rega_wen", int'(REGA_WEN), 0);
      check("rst ccl_en", int'(CCL_EN), 0);
      idle();
      check("rst commit perr", int'(PHASE_ERR), 1);

      // counter wrap from 16'hFFFF
      force dut.commit_cnt_q = 16'hFFFF;
      m_cnt = 65535;
      #1;
      release dut.commit_cnt_q;
      idle();
      check("wrap preload", int'(COMMIT_CNT), 65535);
      fields(3'd1, 2'd0, 3'd0, 4'd1, 4'd2, 1'b0);
      strobe(1, 0, 0, 0);
      strobe(0, 1, 0, 0);
      strobe(0, 0, 1, 0);
      strobe(0, 0, 0, 1);
      idle();
      check("wrap commit_cnt", int'(COMMIT_CNT), 0);

      // mixed strobe traffic, checked by the per-cycle model
      for (int i = 0; i < 300; i++) begin
         int sel;
         sel = $urandom_range(0, 11);
         fields(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         if (sel < 8)
            strobe(sel % 4 == 0, sel % 4 == 1, sel % 4 == 2, sel % 4 == 3);
         else if (sel < 10)
            idle();
         else
            strobe(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);
      end
      idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
